vc_pop_arbiter: RTL and testbench
=================================

Name: vc_pop_arbiter

Overview:
- Shares one downstream transaction-layer path among 8 source FIFOs, one pop per cycle.
- Picks the source by round-robin with a bounded burst per grant.
- Stalls on downstream almost-full; runs only while the layer controller reports ACTIVE (enable).
- Sits between the source FIFO bank, whose empties feed the layer controller, and the shared destination FIFO.

Parameters:
- N_SRC, 8, number of source FIFOs; the design is verified at 8 only.
- ID_W, 3, width of the source index, log2(N_SRC).
- MAX_BURST, 4, maximum consecutive pops per grant, range 1..8.
- CNT_W, 3, width of the burst counter; must hold MAX_BURST-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; clears all state on a clk edge while low.
- enable  in  1  high while the layer controller is in ACTIVE.
- empties  in  N_SRC  bit i high = source FIFO i empty; reflects pops up to the previous edge.
- almost_full  in  1  destination FIFO at its upper bound; no pop while high.
- pop  out  N_SRC  one-hot or zero; combinational read strobe to the source FIFOs.
- data_valid  out  1  registered; high the cycle after a pop (FIFO read latency is 1).
- data_src  out  ID_W  registered; source index qualifying data_valid.
- busy  out  1  registered; high in GRANT state.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - data_valid=0, data_src=0, busy=0, so pop=0.
  - Applies mid-burst as well; the pending data_valid is dropped.
- States, one-hot encoded: IDLE, GRANT.
- pop = onehot(owner) & ~empties, gated by (state==GRANT) & enable & ~almost_full.
  - pop is never asserted to an empty FIFO, even in the cycle after that FIFO's last pop.
- Pick function: first i with empties[i]==0, searching rr_ptr, rr_ptr+1, ... mod N_SRC.
  - req_any = ~&empties.
- IDLE:
  - If enable & req_any: owner=pick, burst_cnt=0, go to GRANT.
  - Otherwise stay. almost_full does not block the grant.
- GRANT, evaluated in this order each edge:
  1. enable==0: go to IDLE, rr_ptr=owner+1.
  2. empties[owner]==1, no pop this cycle: release.
  3. pop this cycle and burst_cnt==MAX_BURST-1: release.
  4. pop this cycle: burst_cnt+1, stay.
  5. almost_full (no pop): hold owner and burst_cnt, stay. Stalling is unbounded.
- Release:
  - rr_ptr=owner+1 mod N_SRC.
  - If req_any, re-grant on the same edge: owner=pick, searched from the new rr_ptr, with burst_cnt=0.
  - Otherwise go to IDLE.
  - The old owner can win again only if it is the only non-empty source.
- Re-grant empties may be stale by one pop. A wrong pick yields one dead GRANT cycle, which is released under rule 2. This is accepted.
- Registered outputs:
  - data_valid <= |pop.
  - data_src <= owner when |pop, else hold.
  - busy <= next_state==GRANT.
- Wrap: rr_ptr and owner arithmetic is modulo N_SRC, so 7+1 = 0.
- Latency:
  - Request seen in IDLE to first pop: 1 cycle.
  - pop to data_valid: 1 cycle.
- Throughput: 1 pop per cycle during a burst. A burst-exhaust handoff with a pending request adds no bubble.

Decomposition:
- Shared package (tl_pkg): N_SRC, ID_W, MAX_BURST default, and the one-hot arbiter state constants, in the same style as the layer controller's RESET/INIT/IDLE/ACTIVE.
- Sub-module rr_pick: combinational rotate-and-priority-encode.
  - Inputs: req[N_SRC-1:0], ptr[ID_W-1:0].
  - Outputs: found, idx[ID_W-1:0].
  - Unit-tested standalone.

Test Plan:
- Reset then enable=1, empties=8'hFF for 10 cycles -> pop=0, busy=0, data_valid=0 throughout.
- empties=8'hFE, FIFO0 holding 6 words, almost_full=0 -> pops on FIFO0 in cycles 1-4; release; FIFO0 re-granted (only requester); pops in cycles 5-6 after no more than 1 dead cycle. data_valid follows each pop by 1 cycle with data_src=0.
- FIFOs 2, 5 and 7 each holding 8 words, rr_ptr=0 -> grant order 2,5,7,2,5,7; exactly 4 pops each per grant; no bubble between grants.
- Mid-burst on FIFO 3, raise almost_full for 5 cycles -> pop=0 and burst_cnt frozen; after deassert, remaining pops complete up to 4 total.
- owner=6 bursting; drop enable -> pop=0 the same cycle, IDLE the next. Re-enable with FIFOs 0 and 7 non-empty -> FIFO 7 granted first (rr_ptr=7). Then assert reset mid-burst -> all outputs 0 on the next edge.
- FIFO 4 holding exactly 1 word -> single pop; the next cycle pop stays 0 despite stale empties; owner released; data_valid pulse of 1 cycle, data_src=4.

Source files
------------

// File: rtl/tl_pkg.sv
// Constants shared by the transaction-layer blocks: source count and index width,
// arbiter defaults and the one-hot arbiter state encoding.
package tl_pkg;
   localparam int N_SRC          = 8;
   localparam int ID_W           = 3;
   localparam int MAX_BURST_DFLT = 4;
   localparam int CNT_W_DFLT     = 3;

   localparam logic [1:0] ARB_IDLE  = 2'b01;
   localparam logic [1:0] ARB_GRANT = 2'b10;
endpackage

// File: rtl/vc_pop_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping modulo N_SRC.
module rr_pick
   import tl_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = ptr + ID_W'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Round-robin pop arbiter: grants one of N_SRC source FIFOs for a bounded burst and
// drives a one-hot pop into it while the downstream path has room.
module vc_pop_arbiter
   import tl_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DFLT,
   parameter int CNT_W     = CNT_W_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_SRC-1:0] empties,
   input  logic             almost_full,
   output logic [N_SRC-1:0] pop,
   output logic             data_valid,
   output logic [ID_W-1:0]  data_src,
   output logic             busy
);

   logic [1:0]       state, next_state;
   logic [ID_W-1:0]  owner, owner_nxt;
   logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

   logic             in_grant, owner_empty, pop_any, last_pop, release_c;
   logic [N_SRC-1:0] req_vec;
   logic [ID_W-1:0]  pick_ptr, pick_idx;
   logic             pick_found;

   logic             vld_p1, busy_p1;
   logic [ID_W-1:0]  src_p1;

   assign in_grant    = (state == ARB_GRANT);
   assign owner_empty = empties[owner];
   assign pop_any     = in_grant & enable & ~almost_full & ~owner_empty;
   assign pop         = pop_any ? (N_SRC'(1) << owner) : '0;
   assign last_pop    = pop_any & (burst_cnt == CNT_W'(MAX_BURST - 1));
   assign release_c   = in_grant & enable & (owner_empty | last_pop);

   // A releasing owner searches from the slot after itself; IDLE searches from rr_ptr.
   assign req_vec  = ~empties;
   assign pick_ptr = in_grant ? owner + ID_W'(1) : rr_ptr;

   rr_pick u_rr_pick (
      .req   (req_vec),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      next_state    = state;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      if (!in_grant) begin
         next_state = ARB_IDLE;
         if (enable && pick_found) begin
            next_state    = ARB_GRANT;
            owner_nxt     = pick_idx;
            burst_cnt_nxt = '0;
         end
      end else if (!enable) begin
         next_state = ARB_IDLE;
         rr_ptr_nxt = owner + ID_W'(1);
      end else if (release_c) begin
         rr_ptr_nxt    = owner + ID_W'(1);
         burst_cnt_nxt = '0;
         if (pick_found) owner_nxt  = pick_idx;
         else            next_state = ARB_IDLE;
      end else if (pop_any) begin
         burst_cnt_nxt = burst_cnt + CNT_W'(1);
      end
   end

   // Stage p1: read strobe registered alongside the FIFO's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ARB_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         vld_p1    <= 1'b0;
         src_p1    <= '0;
         busy_p1   <= 1'b0;
      end else begin
         state     <= next_state;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         vld_p1    <= pop_any;
         if (pop_any) src_p1 <= owner;
         busy_p1   <= (next_state == ARB_GRANT);
      end
   end

   assign data_valid = vld_p1;
   assign data_src   = src_p1;
   assign busy       = busy_p1;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter with a word-count model of the source FIFOs.
module tb_vc_pop_arbiter;

   logic       clk = 1'b0;
   logic       reset, enable, almost_full;
   logic [7:0] empties;
   logic [7:0] pop;
   logic       data_valid;
   logic [2:0] data_src;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int fcnt [8];

   always #5 clk = ~clk;

   vc_pop_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .empties     (empties),
      .almost_full (almost_full),
      .pop         (pop),
      .data_valid  (data_valid),
      .data_src    (data_src),
      .busy        (busy)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic refresh();
      for (int i = 0; i < 8; i++) empties[i] = (fcnt[i] == 0);
   endtask

   // Advance one cycle; FIFOs consume the pop presented before the edge.
   task automatic step();
      logic [7:0] p;
      p = pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) if (p[i] && fcnt[i] > 0) fcnt[i]--;
      refresh();
      @(negedge clk);
   endtask

   function automatic int oh_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic do_reset();
      reset = 1'b0; enable = 1'b0; almost_full = 1'b0;
      for (int i = 0; i < 8; i++) fcnt[i] = 0;
      refresh();
      step(); step();
      reset = 1'b1; enable = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; almost_full = 1'b0;
      for (int i = 0; i < 8; i++) fcnt[i] = 0;
      refresh();
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (pop !== 8'h00) begin miscompares++; $display("FAIL reset pop: got %h want 00", pop); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
      vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset data_valid: got %b want 0", data_valid); end
      vectors++; if (data_src !== 3'd0) begin miscompares++; $display("FAIL reset data_src: got %0d want 0", data_src); end
      fcnt[1] = 5; refresh(); enable = 1'b1;
      step(); #1;
      vectors++; if (pop !== 8'h00) begin miscompares++; $display("FAIL reset_held pop: got %h want 00", pop); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_held busy: got %b want 0", busy); end
      reset = 1'b1;
   endtask

   task automatic test_idle_empty();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         vectors++; if (pop !== 8'h00) begin miscompares++; $display("FAIL idle pop c%0d: got %h want 00", c, pop); end
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle busy c%0d: got %b want 0", c, busy); end
         vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL idle data_valid c%0d: got %b want 0", c, data_valid); end
         step();
      end
   endtask

   task automatic test_single_src();
      logic [7:0] ep [9];
      logic       eb [9];
      logic [7:0] prev;
      ep = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
      eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      prev = 8'h00;
      fcnt[0] = 6; refresh();
      for (int c = 0; c < 9; c++) begin
         #1;
         vectors++; if (pop !== ep[c]) begin miscompares++; $display("FAIL single_src pop c%0d: got %h want %h", c, pop, ep[c]); end
         vectors++; if (busy !== eb[c]) begin miscompares++; $display("FAIL single_src busy c%0d: got %b want %b", c, busy, eb[c]); end
         vectors++; if (data_valid !== (prev != 0)) begin miscompares++; $display("FAIL single_src data_valid c%0d: got %b want %b", c, data_valid, prev != 0); end
         if (prev != 0) begin
            vectors++; if (data_src !== 3'(oh_idx(prev))) begin miscompares++; $display("FAIL single_src data_src c%0d: got %0d want %0d", c, data_src, oh_idx(prev)); end
         end
         prev = ep[c];
         step();
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] order [6];
      logic [7:0] ep;
      logic       eb;
      logic [7:0] prev;
      order = '{8'h04, 8'h20, 8'h80, 8'h04, 8'h20, 8'h80};
      do_reset();
      prev = 8'h00;
      fcnt[2] = 8; fcnt[5] = 8; fcnt[7] = 8; refresh();
      for (int c = 0; c < 27; c++) begin
         ep = (c >= 1 && c <= 24) ? order[(c - 1) / 4] : 8'h00;
         eb = (c >= 1 && c <= 25);
         #1;
         vectors++; if (pop !== ep) begin miscompares++; $display("FAIL rr pop c%0d: got %h want %h", c, pop, ep); end
         vectors++; if (busy !== eb) begin miscompares++; $display("FAIL rr busy c%0d: got %b want %b", c, busy, eb); end
         vectors++; if (data_valid !== (prev != 0)) begin miscompares++; $display("FAIL rr data_valid c%0d: got %b want %b", c, data_valid, prev != 0); end
         if (prev != 0) begin
            vectors++; if (data_src !== 3'(oh_idx(prev))) begin miscompares++; $display("FAIL rr data_src c%0d: got %0d want %0d", c, data_src, oh_idx(prev)); end
         end
         prev = ep;
         step();
      end
   endtask

   task automatic test_stall();
      logic [7:0] ep [14];
      logic [7:0] prev;
      ep = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h08, 8'h08, 8'h20, 8'h20, 8'h00, 8'h08};
      do_reset();
      prev = 8'h00;
      fcnt[3] = 8; fcnt[5] = 2; refresh();
      for (int c = 0; c < 14; c++) begin
         if (c == 3) almost_full = 1'b1;
         if (c == 8) almost_full = 1'b0;
         #1;
         vectors++; if (pop !== ep[c]) begin miscompares++; $display("FAIL stall pop c%0d: got %h want %h", c, pop, ep[c]); end
         vectors++; if (busy !== (c != 0)) begin miscompares++; $display("FAIL stall busy c%0d: got %b want %b", c, busy, c != 0); end
         vectors++; if (data_valid !== (prev != 0)) begin miscompares++; $display("FAIL stall data_valid c%0d: got %b want %b", c, data_valid, prev != 0); end
         if (prev != 0) begin
            vectors++; if (data_src !== 3'(oh_idx(prev))) begin miscompares++; $display("FAIL stall data_src c%0d: got %0d want %0d", c, data_src, oh_idx(prev)); end
         end
         prev = ep[c];
         step();
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] ep [9];
      logic       eb [9];
      logic [7:0] prev;
      ep = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00};
      eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      prev = 8'h00;
      fcnt[6] = 8; refresh();
      for (int c = 0; c < 9; c++) begin
         if (c == 3) enable = 1'b0;
         if (c == 5) begin fcnt[0] = 3; fcnt[7] = 3; refresh(); enable = 1'b1; end
         if (c == 7) reset = 1'b0;
         if (c == 8) prev = 8'h00;
         #1;
         vectors++; if (pop !== ep[c]) begin miscompares++; $display("FAIL enable pop c%0d: got %h want %h", c, pop, ep[c]); end
         vectors++; if (busy !== eb[c]) begin miscompares++; $display("FAIL enable busy c%0d: got %b want %b", c, busy, eb[c]); end
         vectors++; if (data_valid !== (prev != 0)) begin miscompares++; $display("FAIL enable data_valid c%0d: got %b want %b", c, data_valid, prev != 0); end
         if (prev != 0) begin
            vectors++; if (data_src !== 3'(oh_idx(prev))) begin miscompares++; $display("FAIL enable data_src c%0d: got %0d want %0d", c, data_src, oh_idx(prev)); end
         end
         if (c == 8) begin
            vectors++; if (data_src !== 3'd0) begin miscompares++; $display("FAIL midburst_reset data_src: got %0d want 0", data_src); end
         end
         prev = ep[c];
         step();
      end
      reset = 1'b1;
   endtask

   task automatic test_single_word();
      logic [7:0] ep [4];
      logic       eb [4];
      logic [7:0] prev;
      ep = '{8'h00, 8'h10, 8'h00, 8'h00};
      eb = '{1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      prev = 8'h00;
      fcnt[4] = 1; refresh();
      for (int c = 0; c < 4; c++) begin
         #1;
         vectors++; if (pop !== ep[c]) begin miscompares++; $display("FAIL single_word pop c%0d: got %h want %h", c, pop, ep[c]); end
         vectors++; if (busy !== eb[c]) begin miscompares++; $display("FAIL single_word busy c%0d: got %b want %b", c, busy, eb[c]); end
         vectors++; if (data_valid !== (prev != 0)) begin miscompares++; $display("FAIL single_word data_valid c%0d: got %b want %b", c, data_valid, prev != 0); end
         if (prev != 0) begin
            vectors++; if (data_src !== 3'(oh_idx(prev))) begin miscompares++; $display("FAIL single_word data_src c%0d: got %0d want %0d", c, data_src, oh_idx(prev)); end
         end
         prev = ep[c];
         step();
      end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; almost_full = 1'b0; empties = 8'hFF;
      test_reset();
      test_idle_empty();
      test_single_src();
      test_round_robin();
      test_stall();
      test_enable_drop();
      test_single_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
